mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single core memory bus between the fetch unit (instruction port) and the integer execution unit's load/store path (data port).
- Arbitrates pending requests, registers the winner's payload onto the bus, and holds it until the bus acknowledges.
- Returns a one-cycle done/read-data pulse to the winning requester.
- Data has priority, so a stalled IEU drains first; a streak limit bounds fetch starvation.
- Supports fetch cancellation on taken jumps.

Parameters:
- XLEN, 32, data/address width.
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch is pending; the fetch wins the next arbitration. Minimum 1.

Ports:
- clk  in  1  core clock
- rst_n  in  1  async active-low reset
- i_req  in  1  fetch request; held high, with i_addr stable, until i_done or i_flush
- i_addr  in  XLEN  fetch address
- i_flush  in  1  cancel any pending or in-flight fetch (jump taken)
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  XLEN  fetched word
- d_req  in  1  data request; held high, with payload stable, until d_done
- d_we  in  1  1 = store, 0 = load
- d_funct3  in  3  access size/sign, passed to bus unchanged
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_done  out  1  one-cycle pulse: data access complete; d_rdata valid for loads
- d_rdata  out  XLEN  load data
- bus_req  out  1  bus transaction active
- bus_we  out  1  bus write enable
- bus_funct3  out  3  bus access size; 3'b010 (word) for fetches
- bus_addr  out  XLEN  bus address
- bus_wdata  out  XLEN  bus write data
- bus_ack  in  1  one-cycle completion from bus; bus_rdata valid the same cycle
- bus_rdata  in  XLEN  bus read data

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; streak = 0; flush_pend = 0.
  - All outputs 0: bus_req, bus_we, bus_funct3, bus_addr, bus_wdata, i_done, i_rdata, d_done, d_rdata.
  - Reset asserted mid-transaction abandons it; no done pulse is issued afterwards.
- States: IDLE, I_BUSY, D_BUSY, DONE.
- IDLE, arbitration each cycle:
  - If d_req and not (i_req and streak >= MAX_D_STREAK): grant data. Latch d_we/d_funct3/d_addr/d_wdata into the bus registers; next state D_BUSY.
  - Else if i_req and not i_flush: grant fetch. Latch i_addr; bus_we = 0; bus_funct3 = 3'b010; next state I_BUSY.
  - Else stay in IDLE.
- Streak counter:
  - A data grant while i_req is high increments streak, saturating at MAX_D_STREAK.
  - A fetch grant clears it.
  - A data grant with i_req low also clears it.
- I_BUSY / D_BUSY:
  - bus_req = 1; bus payload registers held constant.
  - On bus_ack: capture bus_rdata, drop bus_req, go to DONE.
- DONE, one cycle:
  - Pulse d_done, or pulse i_done unless flush_pend is set.
  - i_rdata/d_rdata hold the captured data and stay stable until the next completion on that port.
  - Then go to IDLE and clear flush_pend.
- Latency:
  - Request seen in IDLE at cycle N gives bus_req high at N+1.
  - bus_ack at cycle M gives the done pulse at M+1.
  - Next arbitration happens at M+2.
  - Minimum 3 cycles per access (ack at N+1).
- Flush:
  - i_flush in IDLE blocks the fetch grant that cycle.
  - i_flush in I_BUSY sets flush_pend. The bus transaction still completes (no bus abort), but i_done is suppressed.
  - i_flush in D_BUSY or DONE does not affect the data access.
- Simultaneous d_req and i_req: data wins unless the streak limit is reached.
- Back-to-back: a requester holding its req after its done pulse is re-arbitrated in IDLE like any new request.
- bus_ack outside I_BUSY/D_BUSY is ignored.
- Writes: d_rdata is not updated on a store completion; only d_done pulses.

Test Plan:
- Single fetch: i_req with i_addr=0x100; bus_ack 2 cycles after bus_req with rdata=0xDEADBEEF.
  -> bus_addr=0x100, bus_we=0, bus_funct3=3'b010; i_done pulses 1 cycle after ack; i_rdata=0xDEADBEEF.
- Contention: i_req and d_req (load, addr=0x2000) rise in the same cycle.
  -> data served first (bus_addr=0x2000, d_done); fetch served in the next arbitration.
- Starvation guard: MAX_D_STREAK=4; d_req and i_req both held continuously.
  -> grant order D,D,D,D,I,D,...; streak returns to 0 after the I grant.
- Store: d_we=1, d_funct3=3'b000, d_addr=0x3003, d_wdata=0xAB.
  -> bus_we=1 and the same payload held until ack; d_done pulses; d_rdata unchanged.
- Flush in flight: i_flush pulsed while in I_BUSY.
  -> bus completes on ack; no i_done; IDLE 2 cycles after ack; a following d_req is granted normally.
- Reset mid-access: rst_n low while in D_BUSY.
  -> bus_req=0 immediately (asynchronous); no d_done after release; first post-reset request starts from IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the core memory bus: the fetch port and the load/store port share one bus.
// Data wins ties, and a streak limit stops fetches from starving.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  input  logic            i_flush,
  output logic            i_done,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [2:0]      d_funct3,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_done,
  output logic [XLEN-1:0] d_rdata,
  output logic            bus_req,
  output logic            bus_we,
  output logic [2:0]      bus_funct3,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  // state  | meaning
  // IDLE   | arbitrate pending requests
  // I_BUSY | fetch on the bus, waiting for ack
  // D_BUSY | load/store on the bus, waiting for ack
  // DONE   | one-cycle done pulse to the winner
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_e;

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  state_e            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              flush_pend_q, flush_pend_d;
  logic              owner_d_q, owner_d_d;
  logic              bus_we_q, bus_we_d;
  logic [2:0]        bus_funct3_q, bus_funct3_d;
  logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
  logic [XLEN-1:0]   i_rdata_q, i_rdata_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
  logic              limit_hit;

  assign limit_hit = i_req && (streak_q >= STREAK_MAX);

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    flush_pend_d = flush_pend_q;
    owner_d_d    = owner_d_q;
    bus_we_d     = bus_we_q;
    bus_funct3_d = bus_funct3_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (d_req && !limit_hit) begin
          state_d      = D_BUSY;
          owner_d_d    = 1'b1;
          bus_we_d     = d_we;
          bus_funct3_d = d_funct3;
          bus_addr_d   = d_addr;
          bus_wdata_d  = d_wdata;
          if (!i_req)
            streak_d = '0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + SW'(1);
        end else if (i_req && !i_flush) begin
          state_d      = I_BUSY;
          owner_d_d    = 1'b0;
          bus_we_d     = 1'b0;
          bus_funct3_d = 3'b010;
          bus_addr_d   = i_addr;
          streak_d     = '0;
        end
      end
      I_BUSY: begin
        if (i_flush)
          flush_pend_d = 1'b1;
        if (bus_ack) begin
          state_d = DONE;
          // A cancelled fetch is not a completion, so the previous word stays visible.
          if (!(flush_pend_q || i_flush))
            i_rdata_d = bus_rdata;
        end
      end
      D_BUSY: begin
        if (bus_ack) begin
          state_d = DONE;
          if (!bus_we_q)
            d_rdata_d = bus_rdata;
        end
      end
      DONE: begin
        state_d      = IDLE;
        flush_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      streak_q     <= '0;
      flush_pend_q <= 1'b0;
      owner_d_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_funct3_q <= 3'b000;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      flush_pend_q <= flush_pend_d;
      owner_d_q    <= owner_d_d;
      bus_we_q     <= bus_we_d;
      bus_funct3_q <= bus_funct3_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus_req    = (state_q == I_BUSY) || (state_q == D_BUSY);
  assign bus_we     = bus_we_q;
  assign bus_funct3 = bus_funct3_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign i_done     = (state_q == DONE) && !owner_d_q && !flush_pend_q;
  assign d_done     = (state_q == DONE) && owner_d_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, streak limit, store, flush and reset.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_flush, i_done;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_done;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [2:0]  bus_funct3;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_d, last_i;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_funct3(bus_funct3), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_bus_req(input string tag);
    int n = 0;
    while (bus_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " bus_req"}, 32'(bus_req), 32'd1);
  endtask

  // Waits for the bus, checks the address held for `delay` cycles, then acks; returns at the DONE cycle.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] rdata,
                       input int delay);
    wait_bus_req(tag);
    check_eq({tag, " addr"}, bus_addr, exp_addr);
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      check_eq({tag, " hold addr"}, bus_addr, exp_addr);
      check_eq({tag, " hold req"}, 32'(bus_req), 32'd1);
    end
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
  endtask

  task automatic expect_done(input string tag, input logic ei, input logic ed);
    check_eq({tag, " i_done"}, 32'(i_done), 32'(ei));
    check_eq({tag, " d_done"}, 32'(d_done), 32'(ed));
  endtask

  initial begin
    rst_n = 1'b0; i_req = 0; i_addr = 0; i_flush = 0;
    d_req = 0; d_we = 0; d_funct3 = 0; d_addr = 0; d_wdata = 0;
    bus_ack = 0; bus_rdata = 0;
    repeat (2) @(negedge clk);
    check_eq("rst bus_req", 32'(bus_req), 32'd0);
    check_eq("rst bus_addr", bus_addr, 32'd0);
    check_eq("rst bus_funct3", 32'(bus_funct3), 32'd0);
    check_eq("rst d_rdata", d_rdata, 32'd0);
    expect_done("rst", 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch, ack two cycles after bus_req
    i_req = 1; i_addr = 32'h100;
    @(negedge clk);
    check_eq("fetch latency bus_req", 32'(bus_req), 32'd1);
    check_eq("fetch we", 32'(bus_we), 32'd0);
    check_eq("fetch funct3", 32'(bus_funct3), 32'd2);
    serve("fetch", 32'h100, 32'hDEADBEEF, 2);
    expect_done("fetch done", 1'b1, 1'b0);
    check_eq("fetch i_rdata", i_rdata, 32'hDEADBEEF);
    check_eq("fetch bus_req drop", 32'(bus_req), 32'd0);
    i_req = 0;
    @(negedge clk);
    expect_done("fetch pulse end", 1'b0, 1'b0);
    check_eq("fetch i_rdata stable", i_rdata, 32'hDEADBEEF);
    last_i = 32'hDEADBEEF;

    // Stray ack in IDLE is ignored
    bus_ack = 1; bus_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    bus_ack = 0;
    @(negedge clk);
    expect_done("stray ack", 1'b0, 1'b0);
    check_eq("stray ack d_rdata", d_rdata, 32'd0);

    // Contention: data first, then fetch
    i_req = 1; i_addr = 32'h204; d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h2000;
    serve("cont data", 32'h2000, 32'h12345678, 0);
    expect_done("cont data done", 1'b0, 1'b1);
    check_eq("cont d_rdata", d_rdata, 32'h12345678);
    d_req = 0;
    serve("cont fetch", 32'h204, 32'hCAFE0001, 1);
    expect_done("cont fetch done", 1'b1, 1'b0);
    check_eq("cont i_rdata", i_rdata, 32'hCAFE0001);
    i_req = 0;
    last_d = 32'h12345678;

    // Streak limit: both held, expect D D D D I D D D D I
    i_req = 1; i_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h800;
    for (int k = 0; k < 10; k++) begin
      logic is_f;
      is_f = (k == 4) || (k == 9);
      serve($sformatf("streak%0d", k), is_f ? 32'h400 : 32'h800, 32'h1000 + 32'(k), 0);
      expect_done($sformatf("streak%0d", k), is_f, !is_f);
      if (is_f) last_i = 32'h1000 + 32'(k);
      else      last_d = 32'h1000 + 32'(k);
      if (k == 9) begin
        i_req = 0; d_req = 0;
      end
    end
    check_eq("streak d_rdata", d_rdata, last_d);
    check_eq("streak i_rdata", i_rdata, last_i);

    // Store: payload held, d_rdata untouched
    d_req = 1; d_we = 1; d_funct3 = 3'b000; d_addr = 32'h3003; d_wdata = 32'hAB;
    wait_bus_req("store");
    check_eq("store we", 32'(bus_we), 32'd1);
    check_eq("store funct3", 32'(bus_funct3), 32'd0);
    check_eq("store wdata", bus_wdata, 32'hAB);
    serve("store", 32'h3003, 32'hFFFFFFFF, 2);
    expect_done("store done", 1'b0, 1'b1);
    check_eq("store d_rdata", d_rdata, last_d);
    check_eq("store wdata held", bus_wdata, 32'hAB);
    d_req = 0; d_we = 0;
    @(negedge clk);

    // Flush in IDLE blocks the grant
    i_req = 1; i_addr = 32'h500; i_flush = 1;
    @(negedge clk);
    check_eq("idle flush blocks", 32'(bus_req), 32'd0);
    i_flush = 0;

    // Flush in flight: bus completes, i_done suppressed, data follows normally
    wait_bus_req("flush");
    i_flush = 1;
    @(negedge clk);
    i_flush = 0; i_req = 0;
    serve("flush", 32'h500, 32'h55555555, 1);
    expect_done("flush done", 1'b0, 1'b0);
    check_eq("flush i_rdata", i_rdata, last_i);
    d_req = 1; d_we = 0; d_addr = 32'h600;
    @(negedge clk);
    check_eq("flush idle", 32'(bus_req), 32'd0);
    expect_done("flush idle", 1'b0, 1'b0);
    serve("post flush data", 32'h600, 32'h66, 0);
    expect_done("post flush done", 1'b0, 1'b1);
    d_req = 0;
    @(negedge clk);

    // Reset during D_BUSY
    d_req = 1; d_addr = 32'h700;
    wait_bus_req("rstmid");
    rst_n = 0;
    #1;
    check_eq("rstmid async bus_req", 32'(bus_req), 32'd0);
    check_eq("rstmid bus_addr", bus_addr, 32'd0);
    d_req = 0;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      expect_done("rstmid no done", 1'b0, 1'b0);
    end
    i_req = 1; i_addr = 32'h900;
    @(negedge clk);
    check_eq("rstmid restart", 32'(bus_req), 32'd1);
    serve("rstmid fetch", 32'h900, 32'h99, 0);
    expect_done("rstmid fetch done", 1'b1, 1'b0);
    check_eq("rstmid i_rdata", i_rdata, 32'h99);
    i_req = 0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
